// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: fetch-stage controller for the pipelined MIPS datapath.
// It chooses the next PC (reset vector, sequential, branch or jump target).
// It holds the PC on load-use hazards or on a slow instruction memory.
// It squashes IF/ID for FLUSH_CYCLES cycles after every redirect.
// Optional feature macro: PC_ALIGN_CHECK_EN. When it is defined, a misaligned
// pc_next is replaced by EXC_VECTOR, and the misalign_pulse port is added.
//
// Interface semantics: pc_hold=1 tells the PC register to keep its value.
// pc_hold=0 tells it to load pc_next on the next rising edge. Every output
// except pc_next in BOOT is registered and reacts one edge after its inputs.
module pc_fetch_sequencer #(
   parameter logic [31:0] PC_STEP      = 32'd4,
   parameter int          FLUSH_CYCLES = 1,
`ifdef PC_ALIGN_CHECK_EN
   parameter logic [31:0] EXC_VECTOR   = 32'h80000180,
`endif
   parameter int          WAIT_LIMIT   = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_initial,
   input  logic [31:0] pc_cur,
   input  logic        stall_req,
   input  logic        imem_ready,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic [31:0] pc_next,
   output logic        pc_hold,
   output logic        if_id_flush,
   output logic        fetch_timeout,
`ifdef PC_ALIGN_CHECK_EN
   output logic        misalign_pulse,
`endif
   output logic [1:0]  seq_state
);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_WAIT  = 2'd2,
      S_REDIR = 2'd3
   } state_e;

   // The wait counter must be able to hold WAIT_LIMIT+1, which is its saturation value.
   localparam int             WW         = $clog2(WAIT_LIMIT + 2);
   localparam logic [WW-1:0]  WAIT_SAT   = WW'(WAIT_LIMIT + 1);
   localparam logic [WW-1:0]  WAIT_LIM_W = WW'(WAIT_LIMIT);
   localparam logic [WW-1:0]  WAIT_ONE   = WW'(1);
   localparam logic [1:0]     FLUSH_LOAD = 2'(FLUSH_CYCLES);

   state_e         state_q, state_d;
   logic [31:0]    pc_q, pc_d;
   logic           hold_q, hold_d;
   logic           flush_q, flush_d;
   logic [1:0]     flush_cnt_q, flush_cnt_d;
   logic [WW-1:0]  wait_q, wait_d;
   logic           timeout_q, timeout_d;
   logic           redirect;
   logic [31:0]    target;
   logic [31:0]    seq_pc;
`ifdef PC_ALIGN_CHECK_EN
   logic           misalign_q, misalign_d;
`endif

   // Next-state and next-output selection; priority is redirect > stall > imem wait > sequential.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      hold_d      = hold_q;
      flush_d     = 1'b0;
      flush_cnt_d = flush_cnt_q;
      wait_d      = wait_q;
      timeout_d   = timeout_q;
      redirect    = branch_taken | jump;
      target      = branch_taken ? branch_target : jump_target;
      seq_pc      = pc_cur + PC_STEP;
`ifdef PC_ALIGN_CHECK_EN
      misalign_d  = 1'b0;
`endif

      if (state_q == S_BOOT) begin
         // The reset vector goes to the PC register once, then normal fetch starts.
         pc_d        = pc_initial;
         hold_d      = 1'b0;
         flush_cnt_d = 2'd0;
         wait_d      = '0;
         state_d     = S_RUN;
      end else begin
`ifdef PC_ALIGN_CHECK_EN
         // Any misaligned PC that would be loaded becomes a redirect to the exception vector.
         if (redirect && (target[1:0] != 2'b00)) begin
            target     = EXC_VECTOR;
            misalign_d = 1'b1;
         end else if (!redirect && !stall_req && imem_ready && (seq_pc[1:0] != 2'b00)) begin
            redirect   = 1'b1;
            target     = EXC_VECTOR;
            misalign_d = 1'b1;
         end
`endif
         if (redirect) begin
            // A redirect overrides a stall, ends any memory wait and restarts the flush window.
            pc_d        = target;
            hold_d      = 1'b0;
            state_d     = S_REDIR;
            flush_cnt_d = FLUSH_LOAD;
            flush_d     = 1'b1;
            wait_d      = '0;
         end else begin
            if (stall_req) begin
               hold_d = 1'b1;
            end else if (!imem_ready) begin
               hold_d = 1'b1;
               if (wait_q != WAIT_SAT) begin
                  wait_d = wait_q + WAIT_ONE;
               end
               if (wait_d > WAIT_LIM_W) begin
                  timeout_d = 1'b1;
               end
            end else begin
               pc_d   = seq_pc;
               hold_d = 1'b0;
               wait_d = '0;
            end

            if (state_q == S_REDIR) begin
               // The flush window counts down even while the PC is held.
               flush_cnt_d = flush_cnt_q - 2'd1;
               if (flush_cnt_d != 2'd0) begin
                  flush_d = 1'b1;
               end else if (!stall_req && !imem_ready) begin
                  state_d = S_WAIT;
               end else begin
                  state_d = S_RUN;
               end
            end else if (!stall_req) begin
               state_d = imem_ready ? S_RUN : S_WAIT;
            end
         end
      end
   end

   // State and output registers; the reset is asynchronous and discards pending flush or wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_BOOT;
         pc_q        <= '0;
         hold_q      <= 1'b0;
         flush_q     <= 1'b0;
         flush_cnt_q <= 2'd0;
         wait_q      <= '0;
         timeout_q   <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
         misalign_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         hold_q      <= hold_d;
         flush_q     <= flush_d;
         flush_cnt_q <= flush_cnt_d;
         wait_q      <= wait_d;
         timeout_q   <= timeout_d;
`ifdef PC_ALIGN_CHECK_EN
         misalign_q  <= misalign_d;
`endif
      end
   end

   // In BOOT (including while in reset) the reset vector is presented directly.
   assign pc_next       = (state_q == S_BOOT) ? pc_initial : pc_q;
   assign pc_hold       = hold_q;
   assign if_id_flush   = flush_q;
   assign fetch_timeout = timeout_q;
   assign seq_state     = state_q;
`ifdef PC_ALIGN_CHECK_EN
   assign misalign_pulse = misalign_q;
`endif

endmodule
